// File: rtl/platform_scroller.sv
`default_nettype none
// ============================================================================
// Module   : platform_scroller
// Purpose  : Vertical-scroll generator for evenly spaced platform bands, with
//            continuous and commanded-step scrolling.
// Revision : 1.0 - initial release
// ============================================================================
module platform_scroller #(
    parameter int NUM_PLAT = 4,
    parameter int HEIGHT   = 30,
    parameter int SCREEN_H = 480,
    parameter int SPACING  = 120,
    parameter int TICK_DIV = 840000,
    parameter int DIV_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     step_req,
    input  logic [7:0]               step_lines,
    output logic                     busy,
    output logic                     tick,
    output logic [NUM_PLAT*10-1:0]   plat_start,
    output logic [NUM_PLAT*10-1:0]   plat_end,
    output logic [NUM_PLAT-1:0]      wrap_pulse
);

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_one   = DIV_W'(1);
    localparam logic [9:0]       c_last_line = 10'(SCREEN_H - 1);
    localparam logic [9:0]       c_height    = 10'(HEIGHT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_t;

    state_t               r_state;
    logic [DIV_W-1:0]     r_div;
    logic [7:0]           r_remaining;
    logic                 r_busy;
    logic                 r_tick;
    logic [NUM_PLAT-1:0]  r_wrap;
    logic [9:0]           r_start [NUM_PLAT];

    logic w_tick_evt;
    logic w_accept;
    logic w_move;

    assign w_tick_evt = enable && (r_div == c_div_last);
    assign w_accept   = (r_state == ST_IDLE) && mode && step_req && (step_lines != 8'd0);
    // Step mode moves only while stepping; continuous mode moves only from IDLE,
    // so the cycle that aborts a step never moves the bands.
    assign w_move     = w_tick_evt && (mode ? (r_state == ST_STEP) : (r_state == ST_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_tick      <= 1'b0;
            r_state     <= ST_IDLE;
            r_remaining <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            r_tick <= w_tick_evt;
            if (enable) begin
                r_div <= w_tick_evt ? '0 : (r_div + c_div_one);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= step_lines;
                        r_busy      <= 1'b1;
                        r_state     <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (!mode) begin
                        r_remaining <= 8'd0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_tick_evt) begin
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_start[i] <= 10'(i * SPACING);
                r_wrap[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_wrap[i] <= 1'b0;
                if (w_move) begin
                    if (r_start[i] == c_last_line) begin
                        r_start[i] <= 10'd0;
                        r_wrap[i]  <= 1'b1;
                    end else begin
                        r_start[i] <= r_start[i] + 10'd1;
                    end
                end
            end
        end
    end

    // The end line is left unclipped; the renderer handles overrun past the bottom.
    generate
        for (genvar g = 0; g < NUM_PLAT; g++) begin : g_band_out
            assign plat_start[10*g +: 10] = r_start[g];
            assign plat_end[10*g +: 10]   = r_start[g] + c_height;
        end
    endgenerate

    assign busy       = r_busy;
    assign tick       = r_tick;
    assign wrap_pulse = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_platform_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_platform_scroller
// Purpose  : Scoreboard bench for platform_scroller (3 bands, 4-cycle tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_platform_scroller;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mode;
    logic        step_req;
    logic [7:0]  step_lines;
    logic        busy;
    logic        tick;
    logic [29:0] plat_start;
    logic [29:0] plat_end;
    logic [2:0]  wrap_pulse;

    platform_scroller #(
        .NUM_PLAT (3),
        .HEIGHT   (30),
        .SCREEN_H (480),
        .SPACING  (160),
        .TICK_DIV (4),
        .DIV_W    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .step_req   (step_req),
        .step_lines (step_lines),
        .busy       (busy),
        .tick       (tick),
        .plat_start (plat_start),
        .plat_end   (plat_end),
        .wrap_pulse (wrap_pulse)
    );

    typedef struct packed {
        logic [29:0] starts;
        logic [2:0]  wrap;
        logic        bsy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input int c,
                                input logic [2:0] w, input logic bz);
        exp_t r;
        r.starts = {10'(c), 10'(b), 10'(a)};
        r.wrap   = w;
        r.bsy    = bz;
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every tick pulse consumes one expected record.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got tick with empty queue, expected none");
            end else begin
                e = q.pop_front();
                for (int b = 0; b < 3; b++) begin
                    chk($sformatf("tick_start%0d", b), 32'(plat_start[10*b +: 10]),
                        32'(e.starts[10*b +: 10]));
                    chk($sformatf("tick_end%0d", b), 32'(plat_end[10*b +: 10]),
                        32'(e.starts[10*b +: 10]) + 32'd30);
                end
                chk("tick_wrap", 32'(wrap_pulse), 32'(e.wrap));
                chk("tick_busy", 32'(busy), 32'(e.bsy));
            end
        end else begin
            chk("wrap_without_tick", 32'(wrap_pulse), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; step_req = 1'b0; step_lines = 8'd0;
        cyc(2);
        rst = 1'b0;
        enable = 1'b1;
        chk("rst_start", 32'(plat_start), 32'({10'd320, 10'd160, 10'd0}));
        chk("rst_end", 32'(plat_end), 32'({10'd350, 10'd190, 10'd30}));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);

        // Continuous scroll, then freeze with enable low
        q.push_back(mk(1, 161, 321, 3'b000, 1'b0));
        cyc(4);
        enable = 1'b0;
        cyc(20);
        chk("frozen_start", 32'(plat_start), 32'({10'd321, 10'd161, 10'd1}));
        enable = 1'b1;

        // 160 ticks from reset: band 2 wraps on the last one
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        for (int k = 1; k <= 159; k++)
            q.push_back(mk(k, 160 + k, 320 + k, 3'b000, 1'b0));
        q.push_back(mk(160, 320, 0, 3'b100, 1'b0));
        cyc(640);
        chk("wrap_now", 32'(wrap_pulse), 32'd4);
        cyc(1);
        chk("wrap_gone", 32'(wrap_pulse), 32'd0);

        // Step of 5 lines from reset, then 10 idle ticks
        mode = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        step_req = 1'b1;
        step_lines = 8'd5;
        q.push_back(mk(1, 161, 321, 3'b000, 1'b1));
        q.push_back(mk(2, 162, 322, 3'b000, 1'b1));
        q.push_back(mk(3, 163, 323, 3'b000, 1'b1));
        q.push_back(mk(4, 164, 324, 3'b000, 1'b1));
        q.push_back(mk(5, 165, 325, 3'b000, 1'b0));
        for (int k = 0; k < 10; k++)
            q.push_back(mk(5, 165, 325, 3'b000, 1'b0));
        cyc(1);
        step_req = 1'b0;
        chk("step_busy_rise", 32'(busy), 32'd1);
        cyc(59);

        // Zero-length request is ignored
        step_req = 1'b1;
        step_lines = 8'd0;
        q.push_back(mk(5, 165, 325, 3'b000, 1'b0));
        cyc(1);
        step_req = 1'b0;
        chk("zero_req_busy", 32'(busy), 32'd0);
        cyc(3);

        // Request while busy must not extend the 3-line step
        step_req = 1'b1;
        step_lines = 8'd3;
        q.push_back(mk(6, 166, 326, 3'b000, 1'b1));
        q.push_back(mk(7, 167, 327, 3'b000, 1'b1));
        q.push_back(mk(8, 168, 328, 3'b000, 1'b0));
        q.push_back(mk(8, 168, 328, 3'b000, 1'b0));
        cyc(1);
        chk("busy_req_busy", 32'(busy), 32'd1);
        step_lines = 8'd20;
        cyc(1);
        step_req = 1'b0;
        cyc(14);

        // Mode drop aborts a step; continuous motion resumes
        step_req = 1'b1;
        step_lines = 8'd10;
        q.push_back(mk(9, 169, 329, 3'b000, 1'b1));
        q.push_back(mk(10, 170, 330, 3'b000, 1'b1));
        q.push_back(mk(11, 171, 331, 3'b000, 1'b0));
        q.push_back(mk(12, 172, 332, 3'b000, 1'b0));
        cyc(1);
        step_req = 1'b0;
        cyc(7);
        chk("abort_busy_before", 32'(busy), 32'd1);
        mode = 1'b0;
        cyc(1);
        chk("abort_busy_after", 32'(busy), 32'd0);
        cyc(7);

        // Reset in the middle of a step with 3 lines remaining
        mode = 1'b1;
        step_req = 1'b1;
        step_lines = 8'd5;
        q.push_back(mk(13, 173, 333, 3'b000, 1'b1));
        q.push_back(mk(14, 174, 334, 3'b000, 1'b1));
        cyc(1);
        step_req = 1'b0;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        chk("midrst_start", 32'(plat_start), 32'({10'd320, 10'd160, 10'd0}));
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        q.push_back(mk(0, 160, 320, 3'b000, 1'b0));
        cyc(3);
        chk("midrst_no_early_tick", 32'(tick), 32'd0);
        cyc(1);
        chk("midrst_first_tick", 32'(tick), 32'd1);
        cyc(2);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
